// File: rtl/ras_pkg.sv
// ============================================================================
// ras_pkg : shared defaults, width helpers and checkpoint type for the RAS
// Rev 1.0 | optional top repair adds a field under RAS_TOP_REPAIR_EN
// ============================================================================
`default_nettype none

package ras_pkg;

    localparam int RAS_DEPTH_DEF = 16;
    localparam int RAS_AW_DEF    = 32;

    function automatic int ras_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int ras_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int RAS_PTR_W_DEF = ras_ptr_w(RAS_DEPTH_DEF);
    localparam int RAS_CNT_W_DEF = ras_cnt_w(RAS_DEPTH_DEF);

    // One struct so the pipeline carries the whole checkpoint as a unit
    typedef struct packed {
        logic [RAS_PTR_W_DEF-1:0] ptr;
        logic [RAS_CNT_W_DEF-1:0] cnt;
`ifdef RAS_TOP_REPAIR_EN
        logic [RAS_AW_DEF-1:0]    top;
`endif
    } ras_ckpt_t;

endpackage

`default_nettype wire

// File: rtl/ras_storage.sv
// ============================================================================
// ras_storage : DEPTH x AW register file, 1 sync write, 1 async read port
// Rev 1.0
// ============================================================================
`default_nettype none

module ras_storage #(
    parameter int DEPTH = 16,
    parameter int AW    = 32,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [AW-1:0]    i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [AW-1:0]    o_rdata
);

    logic [AW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/ras_circular.sv
// ============================================================================
// ras_circular : circular return address stack with checkpoint/restore
// Rev 1.0 | RAS_TOP_REPAIR_EN adds restore_top_i / ckpt_top_o top repair
// ============================================================================
`default_nettype none

module ras_circular
    import ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int AW    = RAS_AW_DEF,
    parameter int PTR_W = ras_ptr_w(DEPTH),
    parameter int CNT_W = ras_cnt_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push_i,
    input  logic [AW-1:0]    push_addr_i,
    input  logic             pop_i,
    output logic             hit_o,
    output logic [AW-1:0]    pred_addr_o,
    output logic [PTR_W-1:0] ckpt_ptr_o,
    output logic [CNT_W-1:0] ckpt_cnt_o,
    input  logic             restore_i,
    input  logic [PTR_W-1:0] restore_ptr_i,
    input  logic [CNT_W-1:0] restore_cnt_i,
`ifdef RAS_TOP_REPAIR_EN
    input  logic [AW-1:0]    restore_top_i,
    output logic [AW-1:0]    ckpt_top_o,
`endif
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam logic [CNT_W-1:0] c_full    = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_tos_rst = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_tos;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_udf;

    logic             w_nonempty;
    logic             w_full;
    logic             w_swap;
    logic [PTR_W-1:0] w_tos_inc;
    logic [CNT_W-1:0] w_rcnt;
    logic             w_we;
    logic [PTR_W-1:0] w_waddr;
    logic [AW-1:0]    w_wdata;
    logic [AW-1:0]    w_rdata;

    assign w_nonempty = (r_cnt != '0);
    assign w_full     = (r_cnt == c_full);
    assign w_swap     = push_i && pop_i && w_nonempty;
    assign w_tos_inc  = r_tos + PTR_W'(1);
    assign w_rcnt     = (restore_cnt_i > c_full) ? c_full : restore_cnt_i;

    // Restore and push share the single write port; restore always wins
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_tos_inc;
        w_wdata = push_addr_i;
        if (restore_i) begin
`ifdef RAS_TOP_REPAIR_EN
            w_we    = 1'b1;
            w_waddr = restore_ptr_i;
            w_wdata = restore_top_i;
`endif
        end else if (push_i) begin
            w_we = 1'b1;
            if (w_swap) begin
                w_waddr = r_tos;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_tos <= c_tos_rst;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
            if (restore_i) begin
                r_tos <= restore_ptr_i;
                r_cnt <= w_rcnt;
            end else if (w_swap) begin
                r_tos <= r_tos;
            end else if (push_i) begin
                r_tos <= w_tos_inc;
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (pop_i) begin
                if (w_nonempty) begin
                    r_tos <= r_tos - PTR_W'(1);
                    r_cnt <= r_cnt - CNT_W'(1);
                end else begin
                    r_udf <= 1'b1;
                end
            end
        end
    end

    ras_storage #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk     (CLK),
        .rst     (RESET),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_tos),
        .o_rdata (w_rdata)
    );

    assign hit_o       = pop_i && w_nonempty && !restore_i;
    assign pred_addr_o = w_nonempty ? w_rdata : '0;
    assign ckpt_ptr_o  = r_tos;
    assign ckpt_cnt_o  = r_cnt;
    assign count_o     = r_cnt;
    assign overflow_o  = r_ovf;
    assign underflow_o = r_udf;
`ifdef RAS_TOP_REPAIR_EN
    assign ckpt_top_o  = w_rdata;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ras_circular.sv
// ============================================================================
// tb_ras_circular : directed stimulus with a queue-based expected-value monitor
// Rev 1.0 | build with RAS_TOP_REPAIR_EN to exercise the top repair path
// ============================================================================
`default_nettype none

module tb_ras_circular;

    localparam int DEPTH = 16;
    localparam int AW    = 32;
    localparam int PTR_W = 4;
    localparam int CNT_W = 5;

    logic             CLK;
    logic             RESET;
    logic             push_i;
    logic [AW-1:0]    push_addr_i;
    logic             pop_i;
    logic             hit_o;
    logic [AW-1:0]    pred_addr_o;
    logic [PTR_W-1:0] ckpt_ptr_o;
    logic [CNT_W-1:0] ckpt_cnt_o;
    logic             restore_i;
    logic [PTR_W-1:0] restore_ptr_i;
    logic [CNT_W-1:0] restore_cnt_i;
    logic [AW-1:0]    restore_top_i;
    logic [CNT_W-1:0] count_o;
    logic             overflow_o;
    logic             underflow_o;
`ifdef RAS_TOP_REPAIR_EN
    logic [AW-1:0]    ckpt_top_o;
`endif

    ras_circular #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .push_i        (push_i),
        .push_addr_i   (push_addr_i),
        .pop_i         (pop_i),
        .hit_o         (hit_o),
        .pred_addr_o   (pred_addr_o),
        .ckpt_ptr_o    (ckpt_ptr_o),
        .ckpt_cnt_o    (ckpt_cnt_o),
        .restore_i     (restore_i),
        .restore_ptr_i (restore_ptr_i),
        .restore_cnt_i (restore_cnt_i),
`ifdef RAS_TOP_REPAIR_EN
        .restore_top_i (restore_top_i),
        .ckpt_top_o    (ckpt_top_o),
`endif
        .count_o       (count_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        string       name;
        bit          hit;
        logic [31:0] pred;
        int          cnt;
        int          ptr;
        bit          ovf;
        bit          udf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string n, input string f, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", n, f, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so each cycle's expectation is checked mid-cycle
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "hit",   longint'(hit_o),       longint'(e.hit));
            chk(e.name, "pred",  longint'(pred_addr_o), longint'(e.pred));
            chk(e.name, "count", longint'(count_o),     longint'(e.cnt));
            chk(e.name, "ckcnt", longint'(ckpt_cnt_o),  longint'(e.cnt));
            chk(e.name, "ckptr", longint'(ckpt_ptr_o),  longint'(e.ptr));
            chk(e.name, "ovf",   longint'(overflow_o),  longint'(e.ovf));
            chk(e.name, "udf",   longint'(underflow_o), longint'(e.udf));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_o(input string n, input bit h, input logic [31:0] p,
                            input int c, input int t, input bit ov, input bit un);
        exp_t e;
        e.name = n; e.hit = h; e.pred = p; e.cnt = c; e.ptr = t; e.ovf = ov; e.udf = un;
        q.push_back(e);
    endtask

    task automatic cyc(input string n, input bit ps, input logic [31:0] pa, input bit pp,
                       input bit h, input logic [31:0] p, input int c, input int t,
                       input bit ov, input bit un);
        RESET = 1'b0; restore_i = 1'b0;
        push_i = ps; push_addr_i = pa; pop_i = pp;
        expect_o(n, h, p, c, t, ov, un);
        tick();
    endtask

    task automatic rcyc(input string n, input logic [3:0] rp, input logic [4:0] rc,
                        input logic [31:0] rt, input bit ps, input bit pp,
                        input logic [31:0] p, input int c, input int t);
        RESET = 1'b0; restore_i = 1'b1;
        restore_ptr_i = rp; restore_cnt_i = rc; restore_top_i = rt;
        push_i = ps; push_addr_i = 32'hEE; pop_i = pp;
        expect_o(n, 1'b0, p, c, t, 1'b0, 1'b0);
        tick();
    endtask

    // Reset with push/pop also asserted; reset must override them
    task automatic rst_cyc();
        RESET = 1'b1; restore_i = 1'b0;
        push_i = 1'b1; push_addr_i = 32'h55; pop_i = 1'b1;
        tick();
        cyc("post_rst", 0, 0, 0, 0, 0, 0, 15, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; push_i = 0; push_addr_i = 0; pop_i = 0;
        restore_i = 0; restore_ptr_i = 0; restore_cnt_i = 0; restore_top_i = 0;
        tick(); tick();

        // Underflow on empty
        cyc("idle0",  0, 0, 0, 0, 0, 0, 15, 0, 0);
        cyc("upop",   0, 0, 1, 0, 0, 0, 15, 0, 0);
        cyc("udf",    0, 0, 0, 0, 0, 0, 15, 0, 1);
        cyc("udf_clr",0, 0, 0, 0, 0, 0, 15, 0, 0);

        // LIFO order
        cyc("push1", 1, 32'h100, 0, 0, 0,       0, 15, 0, 0);
        cyc("push2", 1, 32'h200, 0, 0, 32'h100, 1, 0,  0, 0);
        cyc("push3", 1, 32'h300, 0, 0, 32'h200, 2, 1,  0, 0);
        cyc("pop3",  0, 0, 1, 1, 32'h300, 3, 2,  0, 0);
        cyc("pop2",  0, 0, 1, 1, 32'h200, 2, 1,  0, 0);
        cyc("pop1",  0, 0, 1, 1, 32'h100, 1, 0,  0, 0);
        cyc("empty", 0, 0, 0, 0, 0,       0, 15, 0, 0);

        // Overflow: 18 pushes into 16 entries
        rst_cyc();
        for (int i = 0; i < 18; i++) begin
            cyc("ovf_push", 1, 32'h1000 + i, 0, 0, (i == 0) ? 32'h0 : 32'h1000 + i - 1,
                (i > 16) ? 16 : i, (15 + i) % 16, i == 17, 0);
        end
        for (int j = 0; j < 16; j++) begin
            cyc("ovf_pop", 0, 0, 1, 1, 32'h1000 + 17 - j, 16 - j, (17 - j) % 16, j == 0, 0);
        end
        cyc("ovf_pop17", 0, 0, 1, 0, 0, 0, 1, 0, 0);
        cyc("ovf_udf",   0, 0, 0, 0, 0, 0, 1, 0, 1);

        // Simultaneous push+pop
        rst_cyc();
        cyc("pa0",     1, 32'hA0, 0, 0, 0,      0, 15, 0, 0);
        cyc("swap",    1, 32'hB0, 1, 1, 32'hA0, 1, 0,  0, 0);
        cyc("swap_rd", 0, 0,      0, 0, 32'hB0, 1, 0,  0, 0);
        rst_cyc();
        cyc("swap_e",    1, 32'hC0, 1, 0, 0,      0, 15, 0, 0);
        cyc("swap_e_rd", 0, 0,      0, 0, 32'hC0, 1, 0,  0, 0);

        // Checkpoint / restore, push+pop ignored during restore
        rst_cyc();
        cyc("ck_push", 1, 32'h10, 0, 0, 0,      0, 15, 0, 0);
        cyc("ck_cap",  0, 0,      0, 0, 32'h10, 1, 0,  0, 0);
        cyc("ck_p20",  1, 32'h20, 0, 0, 32'h10, 1, 0,  0, 0);
        cyc("ck_p30",  1, 32'h30, 0, 0, 32'h20, 2, 1,  0, 0);
        cyc("ck_pop",  0, 0,      1, 1, 32'h30, 3, 2,  0, 0);
        rcyc("ck_rst", 4'd0, 5'd1, 32'h10, 1, 1, 32'h20, 2, 1);
        cyc("ck_after",0, 0,      0, 0, 32'h10, 1, 0,  0, 0);
        // Restore count above DEPTH clamps to DEPTH
        rcyc("clamp",  4'd2, 5'd31, 32'h30, 0, 0, 32'h10, 1, 0);
        cyc("clamp_rd",0, 0,      0, 0, 32'h30, 16, 2, 0, 0);

        // Top clobbered by wrong-path push+pop
        rst_cyc();
        cyc("tr_push", 1, 32'h40, 0, 0, 0,      0, 15, 0, 0);
        cyc("tr_cap",  0, 0,      0, 0, 32'h40, 1, 0,  0, 0);
        cyc("tr_swap", 1, 32'h99, 1, 1, 32'h40, 1, 0,  0, 0);
        rcyc("tr_rst", 4'd0, 5'd1, 32'h40, 0, 0, 32'h99, 1, 0);
`ifdef RAS_TOP_REPAIR_EN
        cyc("tr_rd",   0, 0,      0, 0, 32'h40, 1, 0,  0, 0);
        chk("tr_top", "ckpt_top", longint'(ckpt_top_o), 64'h40);
`else
        cyc("tr_rd",   0, 0,      0, 0, 32'h99, 1, 0,  0, 0);
`endif

        cyc("drain", 0, 0, 0, 0, 32'h99 ^ 32'h99 ^ pred_exp_last(), 1, 0, 0, 0);
        repeat (3) @(negedge CLK);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [31:0] pred_exp_last();
`ifdef RAS_TOP_REPAIR_EN
        return 32'h40;
`else
        return 32'h99;
`endif
    endfunction

endmodule

`default_nettype wire
